qerv_dbus_ctrl: RTL

- Data-bus sequencer between the core's load/store path and the external Wishbone data port.
- Latches a request from the core: address, size, and store data already lane-aligned by the shift/data buffer register.
- Runs exactly one Wishbone classic cycle, then returns a one-cycle acknowledge.
- For loads, returns the captured read word with a one-cycle load strobe that drives the buffer register's parallel-load input.

---
 rtl/qerv_dbus_pkg.sv | 22 ++
 rtl/qerv_dbus_sel.sv | 35 +++
 rtl/qerv_dbus_ctrl.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/qerv_dbus_pkg.sv
// Shared types and constants for the qerv data-bus sequencer.
package qerv_dbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_RESP   = 2'b10,
        ST_HOLD   = 2'b11
    } dbus_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    localparam int DBUS_TIMEOUT_DEF = 255;

    // Wishbone addresses are word granular; byte position lives in sel.
    function automatic logic [31:0] dbus_word_adr(input logic [29:0] word_idx);
        return {word_idx, 2'b00};
    endfunction

endpackage

// File: rtl/qerv_dbus_sel.sv
// Byte-enable and alignment decode for a data-bus request.
module qerv_dbus_sel
    import qerv_dbus_pkg::*;
(
    input  logic [1:0] i_size,
    input  logic [1:0] i_adr,
    output logic [3:0] o_sel,
    output logic       o_misalign
);

    // Lane decode; size 11 falls through to the word encoding.
    always_comb begin
        o_sel      = 4'b1111;
        o_misalign = 1'b0;
        case (i_size)
            SZ_B: begin
                o_sel      = 4'b0001 << i_adr;
                o_misalign = 1'b0;
            end
            SZ_H: begin
                o_sel      = i_adr[1] ? 4'b1100 : 4'b0011;
                o_misalign = i_adr[0];
            end
            SZ_W: begin
                o_sel      = 4'b1111;
                o_misalign = (i_adr != 2'b00);
            end
            default: begin
                o_sel      = 4'b1111;
                o_misalign = (i_adr != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/qerv_dbus_ctrl.sv
// Data-bus sequencer: one Wishbone classic cycle per core request.
// Optional ACTIVE-state timeout is enabled by defining QERV_DBUS_TIMEOUT_EN.
module qerv_dbus_ctrl
    import qerv_dbus_pkg::*;
#(
    parameter int TIMEOUT = DBUS_TIMEOUT_DEF
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req,
    input  logic [31:0] i_adr,
    input  logic        i_we,
    input  logic [1:0]  i_size,
    input  logic [31:0] i_dat,
    output logic        o_ack,
    output logic        o_err,
    output logic        o_load,
    output logic [31:0] o_rdt,
    output logic [31:0] o_wb_adr,
    output logic [31:0] o_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    input  logic [31:0] i_wb_rdt,
    input  logic        i_wb_ack
);

    dbus_state_e state_q, state_d;

    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic [31:0] rdt_q, rdt_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        load_q, load_d;

    logic [3:0]  req_sel_s;
    logic        misalign_s;
    logic        timeout_s;

    qerv_dbus_sel u_sel (
        .i_size     (i_size),
        .i_adr      (i_adr[1:0]),
        .o_sel      (req_sel_s),
        .o_misalign (misalign_s)
    );

`ifdef QERV_DBUS_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT - 1);

    logic [15:0] cnt_q, cnt_d;

    assign timeout_s = (cnt_q == TIMEOUT_LAST);

    // Counts ACTIVE cycles that went by without a slave acknowledge.
    always_comb begin
        cnt_d = cnt_q;
        if (state_q == ST_IDLE) begin
            cnt_d = 16'd0;
        end else if ((state_q == ST_ACTIVE) && !i_wb_ack) begin
            cnt_d = cnt_q + 16'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q <= 16'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_s;

    assign timeout_s        = 1'b0;
    assign unused_timeout_s = (TIMEOUT != 0);
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            adr_q   <= 32'd0;
            dat_q   <= 32'd0;
            rdt_q   <= 32'd0;
            sel_q   <= 4'd0;
            we_q    <= 1'b0;
            cyc_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            load_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            rdt_q   <= rdt_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            cyc_q   <= cyc_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            load_q  <= load_d;
        end
    end

    // Next-state logic; acks outside ACTIVE never influence the sequence.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    state_d = misalign_s ? ST_RESP : ST_ACTIVE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (i_wb_ack || timeout_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_RESP: state_d = ST_HOLD;
            ST_HOLD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath values registered at the next edge.
    always_comb begin
        adr_d  = adr_q;
        dat_d  = dat_q;
        rdt_d  = rdt_q;
        sel_d  = sel_q;
        we_d   = we_q;
        cyc_d  = 1'b0;
        ack_d  = 1'b0;
        err_d  = 1'b0;
        load_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (i_req) begin
                    adr_d = dbus_word_adr(i_adr[31:2]);
                    dat_d = i_dat;
                    we_d  = i_we;
                    sel_d = req_sel_s;
                    // A misaligned request answers directly and never reaches the bus.
                    if (misalign_s) begin
                        ack_d = 1'b1;
                        err_d = 1'b1;
                    end else begin
                        cyc_d = 1'b1;
                    end
                end else begin
                    cyc_d = 1'b0;
                end
            end
            ST_ACTIVE: begin
                if (i_wb_ack) begin
                    ack_d  = 1'b1;
                    load_d = ~we_q;
                    if (!we_q) begin
                        rdt_d = i_wb_rdt;
                    end else begin
                        rdt_d = rdt_q;
                    end
                end else if (timeout_s) begin
                    ack_d = 1'b1;
                    err_d = 1'b1;
                end else begin
                    cyc_d = 1'b1;
                end
            end
            ST_RESP: cyc_d = 1'b0;
            ST_HOLD: cyc_d = 1'b0;
            default: cyc_d = 1'b0;
        endcase
    end

    assign o_ack    = ack_q;
    assign o_err    = err_q;
    assign o_load   = load_q;
    assign o_rdt    = rdt_q;
    assign o_wb_adr = adr_q;
    assign o_wb_dat = dat_q;
    assign o_wb_sel = sel_q;
    assign o_wb_we  = we_q;
    assign o_wb_cyc = cyc_q;

endmodule
